pump_scheduler: RTL and testbench

PUMP_SCHEDULER -- requirements
Module: pump_scheduler

---
 rtl/pump_scheduler.sv | 149 ++++++++++++++
 tb/tb_pump_scheduler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pump_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pump_scheduler: three-channel scent pump sequencer (IDLE/SPRAY/WAIT).     |
// | Optional macro PUMP_SPRAY_COUNT_EN enables the completed-spray counter.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pump_scheduler #(
  parameter int SEC_DIV   = 1_000_000,
  parameter int SPRAY_SEC = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pump_on,
  input  logic        pump_off,
  input  logic [1:0]  scent_sel,
  input  logic [1:0]  interval_sel,
  output logic [2:0]  pump_en,
  output logic        busy,
  output logic [1:0]  phase,
  output logic [12:0] remain_sec,
  output logic [15:0] spray_count
);

  localparam int DIV_W = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPRAY = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_cnt, div_nxt;
  logic [12:0]        remain_nxt;
  logic [1:0]         scent_q, scent_nxt;
  logic [1:0]         interval_q, interval_nxt;
  logic [2:0]         pump_en_nxt;
  logic               tick, last_sec, spray_done;

  function automatic logic [12:0] wait_len(input logic [1:0] sel);
    case (sel)
      2'd1:    wait_len = 13'd3600;
      2'd2:    wait_len = 13'd7200;
      default: wait_len = 13'd1800;
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] s);
    case (s)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  assign tick     = (div_cnt == DIV_W'(SEC_DIV - 1));
  assign last_sec = (remain_sec == 13'd1);

  always_comb begin
    state_nxt    = state;
    div_nxt      = tick ? '0 : div_cnt + 1'b1;
    remain_nxt   = remain_sec;
    scent_nxt    = scent_q;
    interval_nxt = interval_q;
    spray_done   = 1'b0;
    if (pump_off) begin
      state_nxt  = IDLE;
      div_nxt    = '0;
      remain_nxt = 13'd0;
    end else if (pump_on) begin
      state_nxt  = SPRAY;
      div_nxt    = '0;
      remain_nxt = 13'(SPRAY_SEC);
      scent_nxt  = scent_sel;
    end else begin
      case (state)
        IDLE: begin
          div_nxt    = '0;
          remain_nxt = 13'd0;
        end
        SPRAY: if (tick) begin
          if (last_sec) begin
            state_nxt    = WAIT;
            interval_nxt = interval_sel;
            remain_nxt   = wait_len(interval_sel);
            spray_done   = 1'b1;
          end else begin
            remain_nxt = remain_sec - 13'd1;
          end
        end
        WAIT: if (tick) begin
          if (last_sec) begin
            state_nxt  = SPRAY;
            scent_nxt  = scent_sel;
            remain_nxt = 13'(SPRAY_SEC);
          end else begin
            remain_nxt = remain_sec - 13'd1;
          end
        end
        default: begin
          state_nxt  = IDLE;
          div_nxt    = '0;
          remain_nxt = 13'd0;
        end
      endcase
    end
    // Drive is a function of the state being entered, so it is glitch-free and registered.
    pump_en_nxt = (state_nxt == SPRAY) ? onehot(scent_nxt) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      remain_sec <= 13'd0;
      scent_q    <= 2'd0;
      interval_q <= 2'd0;
      pump_en    <= 3'b000;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      remain_sec <= remain_nxt;
      scent_q    <= scent_nxt;
      interval_q <= interval_nxt;
      pump_en    <= pump_en_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

  assign phase = state;

`ifdef PUMP_SPRAY_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      spray_count <= 16'd0;
    end else if (spray_done && (spray_count != 16'hFFFF)) begin
      spray_count <= spray_count + 16'd1;
    end
  end
`else
  logic unused_spray_done;
  assign unused_spray_done = spray_done;
  assign spray_count       = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pump_scheduler.sv
`default_nettype none
// Directed bench for pump_scheduler at SEC_DIV=4, SPRAY_SEC=2.
module tb_pump_scheduler;

  logic        clk = 1'b0;
  logic        reset, pump_on, pump_off;
  logic [1:0]  scent_sel, interval_sel;
  logic [2:0]  pump_en;
  logic        busy;
  logic [1:0]  phase;
  logic [12:0] remain_sec;
  logic [15:0] spray_count;

  int errors = 0;
  int checks = 0;
  int cnt_exp = 0;

  pump_scheduler #(.SEC_DIV(4), .SPRAY_SEC(2)) dut (
    .clk(clk), .reset(reset), .pump_on(pump_on), .pump_off(pump_off),
    .scent_sel(scent_sel), .interval_sel(interval_sel), .pump_en(pump_en),
    .busy(busy), .phase(phase), .remain_sec(remain_sec), .spray_count(spray_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [1:0] ph, input logic [2:0] pe,
                        input logic [12:0] rs);
    chk({tag, ".phase"}, 32'(phase), 32'(ph));
    chk({tag, ".pump_en"}, 32'(pump_en), 32'(pe));
    chk({tag, ".remain"}, 32'(remain_sec), 32'(rs));
    chk({tag, ".busy"}, 32'(busy), 32'(ph != 2'd0));
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".count"}, 32'(spray_count), 32'(cnt_exp));
  endtask

  task automatic spray_done_cnt();
`ifdef PUMP_SPRAY_COUNT_EN
    cnt_exp++;
`endif
  endtask

  task automatic pulse_on();
    pump_on = 1'b1;
    step(1);
    pump_on = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pump_on = 1'b0; pump_off = 1'b0;
    scent_sel = 2'd0; interval_sel = 2'd0;
    step(2);
    chk_st("reset", 2'd0, 3'b000, 13'd0);
    chk_cnt("reset");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk_st("idle", 2'd0, 3'b000, 13'd0);
    end

    // First spray on Citrus, scent changed mid-spray
    scent_sel = 2'd2; interval_sel = 2'd0;
    pulse_on();
    chk_st("spray1_start", 2'd1, 3'b100, 13'd2);
    step(3);
    scent_sel = 2'd0;
    chk_st("spray1_mid", 2'd1, 3'b100, 13'd2);
    step(4);
    chk_st("spray1_last", 2'd1, 3'b100, 13'd1);
    step(1);
    spray_done_cnt();
    chk_st("wait1_entry", 2'd2, 3'b000, 13'd1800);
    chk_cnt("wait1_entry");
    interval_sel = 2'd3;
    step(4);
    chk_st("wait1_tick", 2'd2, 3'b000, 13'd1799);
    step(7195);
    chk_st("wait1_end", 2'd2, 3'b000, 13'd1);
    step(1);
    chk_st("spray2_start", 2'd1, 3'b001, 13'd2);

    step(7);
    chk_st("spray2_last", 2'd1, 3'b001, 13'd1);
    step(1);
    spray_done_cnt();
    chk_st("wait2_entry_sel3", 2'd2, 3'b000, 13'd1800);
    chk_cnt("wait2_entry");

    // pump_off beats pump_on
    pump_on = 1'b1; pump_off = 1'b1;
    step(1);
    pump_on = 1'b0; pump_off = 1'b0;
    chk_st("on_off_same", 2'd0, 3'b000, 13'd0);
    step(5);
    chk_st("idle_hold", 2'd0, 3'b000, 13'd0);

    // Restart mid-spray with a new scent
    scent_sel = 2'd1;
    pulse_on();
    chk_st("spray3_start", 2'd1, 3'b010, 13'd2);
    step(5);
    chk_st("spray3_late", 2'd1, 3'b010, 13'd1);
    scent_sel = 2'd0;
    pulse_on();
    chk_st("spray3_restart", 2'd1, 3'b001, 13'd2);
    step(7);
    chk_st("spray3_rlast", 2'd1, 3'b001, 13'd1);
    step(1);
    spray_done_cnt();
    chk_st("wait3_entry", 2'd2, 3'b000, 13'd1800);
    chk_cnt("wait3_entry");

    // Abort WAIT with pump_on, then abort spray with pump_off (not counted)
    scent_sel = 2'd2;
    pulse_on();
    chk_st("abort_wait", 2'd1, 3'b100, 13'd2);
    step(3);
    pump_off = 1'b1;
    step(1);
    pump_off = 1'b0;
    chk_st("spray_off", 2'd0, 3'b000, 13'd0);
    chk_cnt("spray_off");

    // Interval 60 min and 120 min
    interval_sel = 2'd1; scent_sel = 2'd0;
    pulse_on();
    step(7);
    chk_st("spray4_last", 2'd1, 3'b001, 13'd1);
    step(1);
    spray_done_cnt();
    chk_st("wait_60", 2'd2, 3'b000, 13'd3600);
    interval_sel = 2'd2;
    pulse_on();
    step(8);
    spray_done_cnt();
    chk_st("wait_120", 2'd2, 3'b000, 13'd7200);
    chk_cnt("wait_120");
    step(4);
    chk_st("wait_120_tick", 2'd2, 3'b000, 13'd7199);

    // Invalid scent keeps timing with no drive
    scent_sel = 2'd3;
    pulse_on();
    chk_st("scent_invalid", 2'd1, 3'b000, 13'd2);
    step(4);
    chk_st("scent_invalid_tick", 2'd1, 3'b000, 13'd1);

    // Reset during an active spray wins over pump_on
    scent_sel = 2'd2;
    pulse_on();
    chk_st("pre_reset", 2'd1, 3'b100, 13'd2);
    reset = 1'b1; pump_on = 1'b1;
    step(1);
    reset = 1'b0; pump_on = 1'b0;
    cnt_exp = 0;
    chk_st("reset_spray", 2'd0, 3'b000, 13'd0);
    chk_cnt("reset_spray");
    step(3);
    chk_st("post_reset_idle", 2'd0, 3'b000, 13'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
